// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU definitions: op encodings, controller states and default latencies.
// The MDU datapath decodes the same constants, so both sides stay in step.
package mdu_issue_ctrl_pkg;

    localparam logic [5:0] MDU_NOP   = 6'h00;
    localparam logic [5:0] MDU_MFHI  = 6'h10;
    localparam logic [5:0] MDU_MTHI  = 6'h11;
    localparam logic [5:0] MDU_MFLO  = 6'h12;
    localparam logic [5:0] MDU_MTLO  = 6'h13;
    localparam logic [5:0] MDU_MULT  = 6'h18;
    localparam logic [5:0] MDU_MULTU = 6'h19;
    localparam logic [5:0] MDU_DIV   = 6'h1a;
    localparam logic [5:0] MDU_DIVU  = 6'h1b;

    localparam int MDU_MULT_LAT = 5;
    localparam int MDU_DIV_LAT  = 10;
    localparam int MDU_CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2
    } mdu_state_e;

    function automatic logic is_mul(input logic [5:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div(input logic [5:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Pipeline <-> MDU issue controller signal bundle.
// master = pipeline/MDU side driving stage status; slave = the controller.
interface mdu_issue_ctrl_if;

    logic       e_valid;
    logic [5:0] e_op;
    logic       d_valid;
    logic       d_mdu_use;
    logic       mdu_busy;
    logic [5:0] mdu_op;
    logic       stall;
    logic       err;

    modport master (
        output e_valid, e_op, d_valid, d_mdu_use, mdu_busy,
        input  mdu_op, stall, err
    );

    modport slave (
        input  e_valid, e_op, d_valid, d_mdu_use, mdu_busy,
        output mdu_op, stall, err
    );

endinterface

// File: rtl/mdu_lat_counter.sv
// Loadable down-counter tracking remaining MDU busy cycles.
// Latency: value reflects load/decrement one cycle after the request.
// Backpressure: none; load has priority over decrement.
module mdu_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign last  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU issue controller: issues each op once and stalls D-stage MDU users.
// Latency: mdu_op/stall combinational in the issue cycle; err registered one cycle.
// Backpressure: holds issue while MDU busy or a mult/div is outstanding.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MDU_MULT_LAT,
    parameter int DIV_LAT  = MDU_DIV_LAT,
    parameter int CNT_W    = MDU_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    mdu_issue_ctrl_if.slave    bus
);

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic             err_q;
    logic             err_d;
    logic             busy_idle_q;
    logic             busy_idle_d;

    logic             issue;
    logic             start;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             waiting;

    assign waiting = (state_q != IDLE);

    // Reset gates issue so an op in E during reset never reaches the MDU twice.
    assign issue = bus.e_valid & ~waiting & ~bus.mdu_busy & ~reset;
    assign start = issue & (is_mul(bus.e_op) | is_div(bus.e_op));

    assign bus.mdu_op = issue ? bus.e_op : MDU_NOP;
    assign bus.stall  = ~reset & bus.d_valid & bus.d_mdu_use
                      & (waiting | start | bus.mdu_busy);
    assign bus.err    = err_q;

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            IDLE: begin
                if (start && is_mul(bus.e_op)) begin
                    state_d      = MUL_WAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(MULT_LAT);
                end else if (start) begin
                    state_d      = DIV_WAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(DIV_LAT);
                end
            end
            MUL_WAIT, DIV_WAIT: begin
                if (cnt_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Busy with no outstanding op is tolerated for one cycle before flagging.
    always_comb begin
        busy_idle_d = ~waiting & (cnt == '0) & bus.mdu_busy;
        err_d       = err_q
                    | (waiting & ~bus.mdu_busy)
                    | (busy_idle_d & busy_idle_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            busy_idle_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            busy_idle_q <= busy_idle_d;
        end
    end

    mdu_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (waiting),
        .value    (cnt),
        .last     (cnt_last)
    );

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench: per-cycle expectations queued by stimulus, checked by a monitor.
module tb_mdu_issue_ctrl;
    import mdu_issue_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mdu_issue_ctrl_if bus();

    mdu_issue_ctrl #(
        .MULT_LAT (5),
        .DIV_LAT  (10),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural MDU busy: busy for the fixed latency after accepting mult/div.
    int   busy_cnt;
    int   busy_mode;
    always @(posedge clk) begin
        if (reset) begin
            busy_cnt <= 0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (bus.mdu_op == MDU_MULT || bus.mdu_op == MDU_MULTU) begin
            busy_cnt <= 5;
        end else if (bus.mdu_op == MDU_DIV || bus.mdu_op == MDU_DIVU) begin
            busy_cnt <= 10;
        end
    end
    assign bus.mdu_busy = (busy_mode == 1) ? 1'b1 :
                          (busy_mode == 2) ? 1'b0 : (busy_cnt != 0);

    typedef struct {
        int         idx;
        logic [5:0] op;
        logic       stall;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   vec_n  = 0;

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h want %0h", nm, idx, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("mdu_op", mon_e.idx, {2'b00, bus.mdu_op}, {2'b00, mon_e.op});
            chk("stall",  mon_e.idx, {7'd0, bus.stall},   {7'd0, mon_e.stall});
            chk("err",    mon_e.idx, {7'd0, bus.err},     {7'd0, mon_e.err});
        end
    end

    // bm: 0 = modelled busy, 1 = force busy high, 2 = force busy low
    task automatic step(input logic rst, input logic ev, input logic [5:0] eop,
                        input logic dv, input logic du,
                        input logic [5:0] x_op, input logic x_stall, input logic x_err,
                        input int bm = 0);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.e_valid   = ev;
        bus.e_op      = eop;
        bus.d_valid   = dv;
        bus.d_mdu_use = du;
        busy_mode     = bm;
        e.idx   = vec_n;
        e.op    = x_op;
        e.stall = x_stall;
        e.err   = x_err;
        exp_q.push_back(e);
        vec_n++;
    endtask

    initial begin
        bus.e_valid   = 1'b0;
        bus.e_op      = MDU_NOP;
        bus.d_valid   = 1'b0;
        bus.d_mdu_use = 1'b0;
        busy_mode     = 0;
        repeat (2) @(posedge clk);

        // Reset with a mult in E and MDU user in D: nothing issues, no stall.
        repeat (2) step(1, 1, MDU_MULT, 1, 1, MDU_NOP, 0, 0);
        repeat (2) step(0, 0, MDU_NOP, 1, 1, MDU_NOP, 0, 0);

        // mult with dependent mflo held in D.
        step(0, 1, MDU_MULT, 1, 1, MDU_MULT, 1, 0);
        repeat (5) step(0, 0, MDU_NOP, 1, 1, MDU_NOP, 1, 0);
        step(0, 0, MDU_NOP, 1, 1, MDU_NOP, 0, 0);
        step(0, 1, MDU_MFLO, 0, 0, MDU_MFLO, 0, 0);
        step(0, 0, MDU_NOP, 0, 0, MDU_NOP, 0, 0);

        // div with independent add in D, then mfhi waits out the divide.
        step(0, 1, MDU_DIV, 1, 0, MDU_DIV, 0, 0);
        step(0, 1, MDU_NOP, 1, 1, MDU_NOP, 1, 0);
        repeat (9) step(0, 0, MDU_NOP, 1, 1, MDU_NOP, 1, 0);
        step(0, 0, MDU_NOP, 1, 1, MDU_NOP, 0, 0);
        step(0, 1, MDU_MFHI, 0, 0, MDU_MFHI, 0, 0);

        // HI/LO moves issue in IDLE with no state change and no stall.
        step(0, 1, MDU_MTHI, 1, 1, MDU_MTHI, 0, 0);
        step(0, 1, MDU_MTLO, 1, 1, MDU_MTLO, 0, 0);

        // Back-to-back mult/multu: multu presented in E throughout but issued 6 later.
        step(0, 1, MDU_MULT, 1, 1, MDU_MULT, 1, 0);
        repeat (5) step(0, 1, MDU_MULTU, 1, 1, MDU_NOP, 1, 0);
        step(0, 1, MDU_MULTU, 0, 0, MDU_MULTU, 0, 0);
        repeat (5) step(0, 0, MDU_NOP, 1, 0, MDU_NOP, 0, 0);
        step(0, 0, MDU_NOP, 0, 0, MDU_NOP, 0, 0);

        // Reset in the third cycle of a divide, then a fresh mult.
        step(0, 1, MDU_DIV, 1, 1, MDU_DIV, 1, 0);
        repeat (2) step(0, 0, MDU_NOP, 1, 1, MDU_NOP, 1, 0);
        step(1, 0, MDU_NOP, 1, 1, MDU_NOP, 0, 0);
        step(0, 0, MDU_NOP, 1, 1, MDU_NOP, 0, 0);
        step(0, 1, MDU_MULT, 0, 0, MDU_MULT, 0, 0);
        repeat (5) step(0, 0, MDU_NOP, 1, 1, MDU_NOP, 1, 0);
        step(0, 0, MDU_NOP, 1, 1, MDU_NOP, 0, 0);

        // MDU drops busy mid-divide: err sticks until reset.
        step(0, 1, MDU_DIV, 0, 0, MDU_DIV, 0, 0);
        repeat (2) step(0, 0, MDU_NOP, 0, 0, MDU_NOP, 0, 0);
        step(0, 0, MDU_NOP, 1, 1, MDU_NOP, 1, 0, 2);
        step(0, 0, MDU_NOP, 1, 1, MDU_NOP, 1, 1);
        repeat (9) step(0, 0, MDU_NOP, 0, 0, MDU_NOP, 0, 1);
        step(1, 0, MDU_NOP, 0, 0, MDU_NOP, 0, 1);
        step(0, 0, MDU_NOP, 0, 0, MDU_NOP, 0, 0);

        // Busy seen in IDLE: blocks issue and stalls; one cycle is tolerated, two is an error.
        step(0, 1, MDU_MULT, 1, 1, MDU_NOP, 1, 0, 1);
        step(0, 0, MDU_NOP, 0, 0, MDU_NOP, 0, 0);
        step(0, 0, MDU_NOP, 0, 0, MDU_NOP, 0, 0, 1);
        step(0, 0, MDU_NOP, 0, 0, MDU_NOP, 0, 0, 1);
        repeat (2) step(0, 0, MDU_NOP, 0, 0, MDU_NOP, 0, 1);
        step(1, 0, MDU_NOP, 0, 0, MDU_NOP, 0, 1);
        step(0, 0, MDU_NOP, 0, 0, MDU_NOP, 0, 0);

        @(negedge clk);
        #1;
        chk("drain", vec_n, 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
